sync_fifo_stream_rd: RTL and testbench
======================================

# sync_fifo_stream_rd

Read-side drain engine for the team's show-ahead synchronous FIFO. It pops words from the FIFO (`rd_en`/`empty`/`dout` style) and presents them on a registered valid/ready stream toward the downstream consumer. It frames the stream into fixed-length packets and keeps beat/packet statistics. It sits directly on the FIFO read port, with the FIFO between producer logic and any valid/ready sink.

## Interface
- `DSIZE`, default 8, word width; must match the FIFO `DSIZE`.
- `PKT_LEN`, default 4, beats per packet, ≥1.
- `CSIZE`, default 16, width of the statistics counters.

- `clk` input, 1 bit, single clock for all logic.
- `rst` input, 1 bit, reset: one clock; reset is synchronous and active-high.
- `enable` input, 1 bit, permits popping the FIFO.
- `fifo_dout` input, DSIZE bits, FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty` input, 1 bit, FIFO empty flag.
- `fifo_rd_en` output, 1 bit, pop strobe; the FIFO advances at the clock edge where this is 1.
- `m_data` output, DSIZE bits, stream data.
- `m_valid` output, 1 bit, stream valid.
- `m_last` output, 1 bit, final beat of a packet.
- `m_ready` input, 1 bit, downstream accept.
- `word_cnt` output, CSIZE bits, accepted-beat count, wraps.
- `pkt_cnt` output, CSIZE bits, completed-packet count, wraps.

## Operation
- Two-entry internal buffer: a head register drives `m_data`, and a skid register holds the second word. `occ` ∈ {0,1,2}.
- Pop rule (combinational): `fifo_rd_en` = `enable` & ~`fifo_empty` & (`occ`≠2) & ~`rst`.
  - There is no combinational path from `m_ready` to `fifo_rd_en`.
- Accept: `acc` = `m_valid` & `m_ready`. `m_valid` = (`occ`≠0), taken from registers.
- Buffer update per edge, with `pop`=`fifo_rd_en`:
  - `acc` & ~`pop`: head←skid if `occ`=2; `occ`−1.
  - `pop` & ~`acc`: the word goes to head if `occ`=0, else to skid; `occ`+1.
  - `pop` & `acc` with `occ`=1: head←`fifo_dout`; `occ` stays 1.
  - `pop` & `acc` with `occ`=2: cannot occur, because the pop is blocked.
- Ordering is strictly FIFO. No word is lost or duplicated.
- Stability: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` are held stable.
- Framing uses a beat counter `bcnt`, range 0..PKT_LEN−1.
  - `m_last` = `m_valid` & (`bcnt`=PKT_LEN−1).
  - On `acc`: `bcnt` increments, or wraps to 0 when `m_last`=1.
  - With PKT_LEN=1, `m_last`=`m_valid` on every beat.
- Statistics:
  - `word_cnt` increments by 1 on every `acc`.
  - `pkt_cnt` increments by 1 on `acc` & `m_last`.
  - Both wrap modulo 2^CSIZE.
- `enable`=0 stops popping only. Buffered words still drain. `bcnt` is preserved, so the packet continues when `enable` returns.
- `fifo_empty`=1 gaps produce `m_valid` bubbles and do not affect `bcnt`.
- Reset values: `occ`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `bcnt`=0, `word_cnt`=0, `pkt_cnt`=0, `fifo_rd_en`=0.
- Reset mid-packet discards buffered words. The next accepted beat starts a new packet.
- Reset dominates all other inputs in the same cycle.

## Timing
- Latency: a word popped at edge N appears with `m_valid`=1 in the cycle after edge N.
- Throughput: one beat per cycle sustained when `m_ready`=1 and the FIFO is non-empty, with `occ` steady at 1.
- Backpressure:
  - After `m_ready` falls, at most 2 words are held and `fifo_rd_en` drops once `occ`=2.
  - After `m_ready` rises, the first pop occurs on the same cycle that `occ` falls below 2, i.e. one cycle after the accept that frees the skid.
- First cycle after `rst` deasserts: `fifo_rd_en` may assert if `enable`=1 and `fifo_empty`=0.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `fifo_empty`=0, `enable`=1, `m_ready`=1.
  - Required: `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `word_cnt`=0, `pkt_cnt`=0 throughout.
- **Streaming:** FIFO preloaded with 0x10..0x17, `m_ready`=1, PKT_LEN=4.
  - Required: 8 consecutive pops; `m_valid` high for 8 consecutive cycles starting 1 cycle after the first pop; data 0x10..0x17 in order.
  - Required: `m_last` on 0x13 and 0x17; final `word_cnt`=8, `pkt_cnt`=2.
- **Backpressure:** same preload with `m_ready`=0 for 10 cycles, then 1.
  - Required: exactly 2 pops, then `fifo_rd_en`=0; `m_data`=0x10 held stable.
  - Required after release: 0x10..0x17 with no gap beyond one cycle and no loss or duplication.
- **Bubbles and enable:** words 0xA0..0xA5 arrive with `fifo_empty` toggling every other cycle; `enable` drops for 5 cycles after the 2nd pop.
  - Required: `m_valid` bubbles; 2 words still drain while `enable`=0.
  - Required: `m_last` on 0xA3 (the 4th accepted beat); `bcnt` continues across the gap.
- **Reset mid-packet:** after 2 beats are accepted and `occ`=2, assert `rst` for 1 cycle, then stream 0x30..0x33.
  - Required: the buffered words never appear; `m_last` on 0x33; `word_cnt`=4, `pkt_cnt`=1.
- **Wrap:** CSIZE=4, PKT_LEN=1, 17 beats accepted.
  - Required: `word_cnt`=1, `pkt_cnt`=1, `m_last`=1 on every beat.

Source files
------------

// File: rtl/sync_fifo_stream_rd.sv
// Read-side drain engine for the show-ahead synchronous FIFO: pops head words into a
// two-entry head/skid buffer and presents them as a framed valid/ready stream with statistics.
module sync_fifo_stream_rd #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CSIZE   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CSIZE-1:0] word_cnt,
  output logic [CSIZE-1:0] pkt_cnt
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    OCC_ZERO = 2'd0,
    OCC_ONE  = 2'd1,
    OCC_TWO  = 2'd2
  } occ_t;

  occ_t             occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [BW-1:0]    bcnt_q;
  logic             pop;
  logic             acc;

  // Pop decision looks only at registered occupancy, never at m_ready.
  assign pop        = enable & ~fifo_empty & (occ_q != OCC_TWO) & ~rst;
  assign fifo_rd_en = pop;

  assign m_valid = (occ_q != OCC_ZERO);
  assign m_data  = head_q;
  assign m_last  = m_valid & (bcnt_q == LAST_BEAT);
  assign acc     = m_valid & m_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case ({pop, acc})
      2'b01: begin
        if (occ_q == OCC_TWO) begin
          head_d = skid_q;
          occ_d  = OCC_ONE;
        end else begin
          occ_d  = OCC_ZERO;
        end
      end
      2'b10: begin
        if (occ_q == OCC_ZERO) begin
          head_d = fifo_dout;
          occ_d  = OCC_ONE;
        end else begin
          skid_d = fifo_dout;
          occ_d  = OCC_TWO;
        end
      end
      // Simultaneous pop and accept only happens with one word held.
      2'b11: head_d = fifo_dout;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_ZERO;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Beat position survives enable drops and empty gaps; it only moves on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q   <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (acc) begin
      word_cnt <= word_cnt + CSIZE'(1);
      if (m_last) begin
        bcnt_q  <= '0;
        pkt_cnt <= pkt_cnt + CSIZE'(1);
      end else begin
        bcnt_q  <= bcnt_q + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// Directed self-checking bench for sync_fifo_stream_rd with a behavioural show-ahead FIFO
// feeding the default instance and a free-running source feeding a small wrap-test instance.
module tb_sync_fifo_stream_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] word_cnt;
  logic [15:0] pkt_cnt;

  logic        enable2;
  logic        fifo_empty2;
  logic        fifo_rd_en2;
  logic [7:0]  fifo_dout2 = 8'h50;
  logic [7:0]  m_data2;
  logic        m_valid2;
  logic        m_last2;
  logic        m_ready2;
  logic [3:0]  word_cnt2;
  logic [3:0]  pkt_cnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  int   rd_ptr    = 0;
  int   wr_ptr    = 0;
  int   pop_count = 0;
  logic gap;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || gap;
  assign fifo_dout  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  always @(posedge clk) begin
    if (fifo_rd_en2) fifo_dout2 <= fifo_dout2 + 8'd1;
  end

  sync_fifo_stream_rd #(.DSIZE(8), .PKT_LEN(4), .CSIZE(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .word_cnt(word_cnt), .pkt_cnt(pkt_cnt)
  );

  sync_fifo_stream_rd #(.DSIZE(8), .PKT_LEN(1), .CSIZE(4)) dut_wrap (
    .clk(clk), .rst(rst), .enable(enable2), .fifo_dout(fifo_dout2),
    .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2), .m_data(m_data2),
    .m_valid(m_valid2), .m_last(m_last2), .m_ready(m_ready2),
    .word_cnt(word_cnt2), .pkt_cnt(pkt_cnt2)
  );

  task automatic load_word(input logic [7:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  // One-cycle reset ending on a negedge with all stimulus idle and the FIFO model emptied.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; m_ready = 1'b0; m_ready2 = 1'b0; gap = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
      checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", m_last); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
      checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
      checks++; if (fifo_rd_en2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en_wrap: got %b expected 0", fifo_rd_en2); end
    end
    enable = 1'b0; enable2 = 1'b0; m_ready = 1'b0; m_ready2 = 1'b0;
    rst = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_streaming();
    logic [7:0] exp;
    do_reset();
    for (int w = 0; w < 8; w++) load_word(8'h10 + 8'(w));
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      checks++; if (fifo_rd_en !== (i <= 7)) begin errors++; $display("[TB] FAIL stream_rd_en[%0d]: got %b expected %b", i, fifo_rd_en, (i <= 7)); end
      checks++; if (m_valid !== (i >= 1 && i <= 8)) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", i, m_valid, (i >= 1 && i <= 8)); end
      if (i >= 1 && i <= 8) begin
        exp = 8'h10 + 8'(i - 1);
        checks++; if (m_data !== exp) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, m_data, exp); end
        checks++; if (m_last !== (i == 4 || i == 8)) begin errors++; $display("[TB] FAIL stream_last[%0d]: got %b expected %b", i, m_last, (i == 4 || i == 8)); end
      end
      @(negedge clk);
    end
    checks++; if (word_cnt !== 16'd8) begin errors++; $display("[TB] FAIL stream_word_cnt: got %0d expected 8", word_cnt); end
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("[TB] FAIL stream_pkt_cnt: got %0d expected 2", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int base;
    int k;
    int gaps;
    logic [7:0] exp;
    do_reset();
    for (int w = 0; w < 8; w++) load_word(8'h10 + 8'(w));
    base = pop_count;
    m_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (fifo_rd_en !== (i < 2)) begin errors++; $display("[TB] FAIL bp_rd_en[%0d]: got %b expected %b", i, fifo_rd_en, (i < 2)); end
      if (i >= 1) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h10) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=10", i, m_valid, m_data); end
      end
      @(negedge clk);
    end
    checks++; if (pop_count - base !== 2) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 2", pop_count - base); end
    m_ready = 1'b1;
    k = 0; gaps = 0;
    for (int c = 0; c < 12 && k < 8; c++) begin
      #1;
      if (m_valid) begin
        exp = 8'h10 + 8'(k);
        checks++; if (m_data !== exp) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, m_data, exp); end
        checks++; if (m_last !== (k == 3 || k == 7)) begin errors++; $display("[TB] FAIL bp_last[%0d]: got %b expected %b", k, m_last, (k == 3 || k == 7)); end
        k++;
      end else begin
        gaps++;
      end
      @(negedge clk);
    end
    checks++; if (k !== 8) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 8", k); end
    checks++; if (gaps > 1) begin errors++; $display("[TB] FAIL bp_gaps: got %0d expected at most 1", gaps); end
    checks++; if (word_cnt !== 16'd8 || pkt_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_counts: got %0d/%0d expected 8/2", word_cnt, pkt_cnt); end
  endtask

  task automatic test_bubbles_enable();
    int base;
    int k;
    int phase;
    int win;
    int win_acc;
    int bubbles;
    int c;
    logic [7:0] exp;
    do_reset();
    for (int w = 0; w < 6; w++) load_word(8'hA0 + 8'(w));
    base = pop_count;
    k = 0; phase = 0; win = 0; win_acc = 0; bubbles = 0; c = 0;
    while (k < 6 && c < 60) begin
      if (phase == 0 && pop_count - base >= 2) phase = 1;
      if (phase == 1 && win == 5) phase = 2;
      enable  = (phase != 1);
      m_ready = (phase != 0);
      gap     = (c % 2 == 1);
      #1;
      if (phase == 1) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bub_rd_en_disabled[%0d]: got %b expected 0", win, fifo_rd_en); end
        win++;
      end
      if (m_valid && m_ready) begin
        exp = 8'hA0 + 8'(k);
        checks++; if (m_data !== exp) begin errors++; $display("[TB] FAIL bub_data[%0d]: got %h expected %h", k, m_data, exp); end
        checks++; if (m_last !== (k == 3)) begin errors++; $display("[TB] FAIL bub_last[%0d]: got %b expected %b", k, m_last, (k == 3)); end
        if (phase == 1) win_acc++;
        k++;
      end else if (phase == 2 && !m_valid) begin
        bubbles++;
      end
      c++;
      @(negedge clk);
    end
    gap = 1'b0;
    checks++; if (k !== 6) begin errors++; $display("[TB] FAIL bub_beats: got %0d expected 6", k); end
    checks++; if (win_acc !== 2) begin errors++; $display("[TB] FAIL bub_drain: got %0d expected 2", win_acc); end
    checks++; if (bubbles == 0) begin errors++; $display("[TB] FAIL bub_bubbles: got %0d expected nonzero", bubbles); end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    int acc;
    int cyc;
    int k;
    logic [7:0] exp;
    do_reset();
    for (int w = 0; w < 4; w++) load_word(8'h20 + 8'(w));
    base = pop_count;
    enable = 1'b1; acc = 0; cyc = 0;
    while (!(acc >= 2 && pop_count - base >= 4) && cyc < 20) begin
      m_ready = (acc < 2);
      #1;
      if (m_valid && m_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    #1;
    checks++; if (cyc >= 20) begin errors++; $display("[TB] FAIL mid_setup_timeout: got %0d cycles expected under 20", cyc); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h22) begin errors++; $display("[TB] FAIL mid_held: got valid=%b data=%h expected valid=1 data=22", m_valid, m_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || word_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_flush: got valid=%b word_cnt=%0d expected 0/0", m_valid, word_cnt); end
    for (int w = 0; w < 4; w++) load_word(8'h30 + 8'(w));
    m_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 15 && k < 4; c++) begin
      #1;
      if (m_valid) begin
        exp = 8'h30 + 8'(k);
        checks++; if (m_data !== exp) begin errors++; $display("[TB] FAIL mid_data[%0d]: got %h expected %h", k, m_data, exp); end
        checks++; if (m_last !== (k == 3)) begin errors++; $display("[TB] FAIL mid_last[%0d]: got %b expected %b", k, m_last, (k == 3)); end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k !== 4) begin errors++; $display("[TB] FAIL mid_beats: got %0d expected 4", k); end
    checks++; if (word_cnt !== 16'd4 || pkt_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mid_counts: got %0d/%0d expected 4/1", word_cnt, pkt_cnt); end
  endtask

  task automatic test_wrap();
    int issued;
    int acc;
    int cyc;
    do_reset();
    fifo_empty2 = 1'b0; m_ready2 = 1'b1;
    issued = 0; acc = 0; cyc = 0;
    while (acc < 17 && cyc < 60) begin
      enable2 = (issued < 17);
      #1;
      if (fifo_rd_en2) issued++;
      if (m_valid2 && m_ready2) begin
        checks++; if (m_last2 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_last[%0d]: got %b expected 1", acc, m_last2); end
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    enable2 = 1'b0;
    checks++; if (acc !== 17) begin errors++; $display("[TB] FAIL wrap_beats: got %0d expected 17", acc); end
    checks++; if (word_cnt2 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_word_cnt: got %0d expected 1", word_cnt2); end
    checks++; if (pkt_cnt2 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_pkt_cnt: got %0d expected 1", pkt_cnt2); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1; gap = 1'b0;
    enable2 = 1'b1; fifo_empty2 = 1'b0; m_ready2 = 1'b1;
    load_word(8'hEE);
    load_word(8'hEF);
    $display("[TB] starting sync_fifo_stream_rd bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles_enable();
    test_reset_mid_packet();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
